// File: rtl/mem_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// main-memory responder (slave).
interface mem_responder_if #(
  parameter int unsigned ADDRESS_WORD_SIZE = 32,
  parameter int unsigned WORD_SIZE         = 8,
  parameter int unsigned BLOCK_SIZE        = 8
) ();
  logic                          mem_read;
  logic                          mem_write;
  logic [ADDRESS_WORD_SIZE-1:0]  addr;
  logic [WORD_SIZE-1:0]          wr_data;
  logic [WORD_SIZE-1:0]          rd_data;
  logic                          rd_valid;
  logic                          wr_ready;
  logic [$clog2(BLOCK_SIZE)-1:0] beat;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output mem_read, mem_write, addr, wr_data,
    input  rd_data, rd_valid, wr_ready, beat, busy, done, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wr_data,
    output rd_data, rd_valid, wr_ready, beat, busy, done, err
  );
endinterface

// File: rtl/mem_responder.sv
// Main-memory responder: fixed-latency block read/write bursts on a word array.
// Define MEM_RESP_ERR_EN to flag and suppress requests addressing beyond the array.
module mem_responder #(
  parameter int unsigned ADDRESS_WORD_SIZE = 32,
  parameter int unsigned WORD_SIZE         = 8,
  parameter int unsigned BLOCK_SIZE        = 8,
  parameter int unsigned MEM_DEPTH_LOG2    = 10,
  parameter int unsigned LATENCY           = 4
) (
  input logic             clk,
  input logic             rst_b,
  mem_responder_if.slave  bus
);
  localparam int unsigned BL    = $clog2(BLOCK_SIZE);
  localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned CW    = $clog2(LATENCY + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT     = 3'd1;
  localparam logic [2:0] RD_BURST = 3'd2;
  localparam logic [2:0] WR_BURST = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]                state;
  logic                      is_write;
  logic                      err_q;
  logic [CW-1:0]             cnt;
  logic [BL-1:0]             beat;
  logic [MEM_DEPTH_LOG2-1:0] base;
  logic [MEM_DEPTH_LOG2-1:0] idx;
  logic                      oor;
  logic                      unused_addr_hi;
  logic [WORD_SIZE-1:0]      mem [DEPTH];

`ifdef MEM_RESP_ERR_EN
  assign oor = (bus.addr >> MEM_DEPTH_LOG2) != '0;
`else
  assign oor = 1'b0;
`endif
  assign unused_addr_hi = ^bus.addr[ADDRESS_WORD_SIZE-1:MEM_DEPTH_LOG2];

  assign idx = base + MEM_DEPTH_LOG2'(beat);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      is_write <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= '0;
      beat     <= '0;
      base     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // write takes priority; a coincident read is dropped
          if (bus.mem_write || bus.mem_read) begin
            is_write <= bus.mem_write;
            err_q    <= oor;
            base     <= bus.addr[MEM_DEPTH_LOG2-1:0] & ~MEM_DEPTH_LOG2'(BLOCK_SIZE - 1);
            cnt      <= CW'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            beat <= '0;
            if (err_q)         state <= DONE;
            else if (is_write) state <= WR_BURST;
            else               state <= RD_BURST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_BURST, WR_BURST: begin
          beat <= beat + 1'b1;
          if (beat == BL'(BLOCK_SIZE - 1)) state <= DONE;
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; async reset forces IDLE so no write lands after it.
  always_ff @(posedge clk) begin
    if (state == WR_BURST) mem[idx] <= bus.wr_data;
  end

  assign bus.rd_valid = (state == RD_BURST);
  assign bus.wr_ready = (state == WR_BURST);
  assign bus.rd_data  = (state == RD_BURST) ? mem[idx] : '0;
  assign bus.beat     = beat;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
`ifdef MEM_RESP_ERR_EN
  assign bus.err      = (state == DONE) && err_q;
`else
  assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with default parameters.
module tb_mem_responder;
  localparam int unsigned LAT = 4;
  localparam int unsigned BS  = 8;

  logic clk;
  logic rst_b;
  int   errors = 0;
  int   checks = 0;

  mem_responder_if #(.ADDRESS_WORD_SIZE(32), .WORD_SIZE(8), .BLOCK_SIZE(BS)) bus ();

  mem_responder #(
    .ADDRESS_WORD_SIZE(32),
    .WORD_SIZE(8),
    .BLOCK_SIZE(BS),
    .MEM_DEPTH_LOG2(10),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_data"},  32'(bus.rd_data), 32'h0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
    chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'h0);
    chk({tag, "_beat"},     32'(bus.beat), 32'h0);
    chk({tag, "_busy"},     32'(bus.busy), 32'h0);
    chk({tag, "_done"},     32'(bus.done), 32'h0);
    chk({tag, "_err"},      32'(bus.err), 32'h0);
  endtask

  // rst_beat >= 0 pulls reset during that write beat and abandons the burst.
  task automatic do_write(input logic [31:0] a, input logic [7:0] d0,
                          input bit both, input bit poke, input int rst_beat);
    bus.addr = a; bus.mem_write = 1'b1; bus.mem_read = both;
    tick();
    bus.mem_write = 1'b0; bus.mem_read = 1'b0;
    chk("wr_busy_rise", 32'(bus.busy), 32'h1);
    for (int i = 1; i < int'(LAT); i++) begin
      if (poke && i == 1) begin bus.mem_read = 1'b1; bus.addr = 32'h10; end
      tick();
      bus.mem_read = 1'b0;
      chk("wr_wait_ready", 32'(bus.wr_ready), 32'h0);
    end
    tick();
    for (int k = 0; k < int'(BS); k++) begin
      if (k == rst_beat) begin
        rst_b = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        tick();
        rst_b = 1'b1;
        tick();
        return;
      end
      chk("wr_ready", 32'(bus.wr_ready), 32'h1);
      chk("wr_beat",  32'(bus.beat), 32'(k));
      chk("wr_no_rd", 32'(bus.rd_valid), 32'h0);
      bus.wr_data = d0 + 8'(k);
      tick();
    end
    chk("wr_done", 32'(bus.done), 32'h1);
    chk("wr_done_err", 32'(bus.err), 32'h0);
    chk("wr_done_ready", 32'(bus.wr_ready), 32'h0);
    tick();
    chk("wr_after_done", 32'(bus.done), 32'h0);
    chk("wr_after_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("wr_no_2nd_done", 32'(bus.done), 32'h0);
    chk("wr_no_2nd_busy", 32'(bus.busy), 32'h0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [63:0] exp);
    bus.addr = a; bus.mem_read = 1'b1;
    tick();
    bus.mem_read = 1'b0;
    chk("rd_busy_rise", 32'(bus.busy), 32'h1);
    for (int i = 1; i < int'(LAT); i++) begin
      tick();
      chk("rd_wait_valid", 32'(bus.rd_valid), 32'h0);
    end
    tick();
    for (int k = 0; k < int'(BS); k++) begin
      chk("rd_valid", 32'(bus.rd_valid), 32'h1);
      chk("rd_beat",  32'(bus.beat), 32'(k));
      chk("rd_data",  32'(bus.rd_data), 32'(exp[8*k +: 8]));
      chk("rd_no_wr", 32'(bus.wr_ready), 32'h0);
      tick();
    end
    chk("rd_done", 32'(bus.done), 32'h1);
    chk("rd_done_valid", 32'(bus.rd_valid), 32'h0);
    tick();
    chk("rd_after_done", 32'(bus.done), 32'h0);
    chk("rd_after_busy", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    rst_b = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.addr = '0; bus.wr_data = '0;
    #2 rst_b = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    rst_b = 1'b1;
    tick();

    // write 0x10 then fill from an unaligned address in the same block
    do_write(32'h10, 8'hA0, 1'b0, 1'b0, -1);
    do_read(32'h13, 64'hA7A6A5A4A3A2A1A0);

    // simultaneous request: write only
    do_write(32'h20, 8'hB0, 1'b1, 1'b0, -1);
    do_read(32'h20, 64'hB7B6B5B4B3B2B1B0);

    // read request during WAIT of a write is ignored
    do_write(32'h30, 8'hC0, 1'b0, 1'b1, -1);
    do_read(32'h30, 64'hC7C6C5C4C3C2C1C0);
    do_read(32'h10, 64'hA7A6A5A4A3A2A1A0);

    // reset during write beat 3: beats 0-2 land, 3-7 keep prior data
    do_write(32'h40, 8'h50, 1'b0, 1'b0, -1);
    do_write(32'h40, 8'hE0, 1'b0, 1'b0, 3);
    do_read(32'h40, 64'h5756555453E2E1E0);

`ifdef MEM_RESP_ERR_EN
    bus.addr = 32'h400; bus.mem_write = 1'b1; bus.wr_data = 8'hD0;
    tick();
    bus.mem_write = 1'b0;
    for (int i = 1; i < int'(LAT); i++) begin
      tick();
      chk("oor_wait_done", 32'(bus.done), 32'h0);
    end
    tick();
    chk("oor_done", 32'(bus.done), 32'h1);
    chk("oor_err", 32'(bus.err), 32'h1);
    chk("oor_no_wr", 32'(bus.wr_ready), 32'h0);
    tick();
    chk("oor_after_done", 32'(bus.done), 32'h0);
    chk("oor_after_err", 32'(bus.err), 32'h0);
    chk("oor_after_busy", 32'(bus.busy), 32'h0);
`else
    do_write(32'h400, 8'hD0, 1'b0, 1'b0, -1);
    do_read(32'h000, 64'hD7D6D5D4D3D2D1D0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
